// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit LFSR stage, its monitor and benches.
package lfsr_pkg;

    localparam int LFSR_W = 6;
    localparam logic [LFSR_W-1:0] SEED = 6'b111111;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCK
    } mon_state_e;

    // Bit 5 feeds back into bit 0 and is folded into bit 3.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[4], s[3], s[2] ^ s[5], s[1], s[0], s[5]};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One LFSR recurrence step: s -> nxt(s).
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] s_i,
    output logic [LFSR_W-1:0] nxt_o
);

    assign nxt_o = lfsr_next(s_i);

endmodule

// File: rtl/lfsr_monitor.sv
// Checks an LFSR state stream: lock with flywheel, error count, seed period, stuck-at-zero.
module lfsr_monitor
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int STUCK_CNT  = 2,
    parameter int ERR_W      = 8,
    parameter int PER_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] q_in,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [PER_W-1:0]  period,
    output logic              period_valid,
    output logic              stuck_zero
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int NW = $clog2(UNLOCK_CNT + 1);
    localparam int ZW = $clog2(STUCK_CNT + 1);

    mon_state_e        state_q, state_d;
    logic [LFSR_W-1:0] prev_q, prev_d;
    logic [LFSR_W-1:0] pred;
    logic [MW-1:0]     match_cnt_q, match_cnt_d;
    logic [NW-1:0]     miss_cnt_q, miss_cnt_d;
    logic [ZW-1:0]     zero_cnt_q, zero_cnt_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic              seen_seed_q, seen_seed_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              period_valid_q, period_valid_d;

    lfsr_step u_step (
        .s_i   (prev_q),
        .nxt_o (pred)
    );

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        zero_cnt_d     = zero_cnt_q;
        per_cnt_d      = per_cnt_q;
        seen_seed_d    = seen_seed_q;
        err_pulse_d    = 1'b0;
        err_cnt_d      = err_cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    prev_d      = q_in;
                    match_cnt_d = '0;
                    state_d     = SYNC;
                end
                SYNC: begin
                    prev_d = q_in;
                    if (q_in == pred) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == MW'(LOCK_CNT)) begin
                            state_d    = LOCK;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: the prediction advances on its own, so one bad word costs one error.
                    prev_d = pred;
                    if (q_in != pred) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        miss_cnt_d = miss_cnt_q + 1'b1;
                        if (miss_cnt_d == NW'(UNLOCK_CNT)) state_d = HUNT;
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase

            if (q_in == SEED) begin
                if (seen_seed_q) begin
                    period_d       = (per_cnt_q == '1) ? '1 : per_cnt_q + 1'b1;
                    period_valid_d = 1'b1;
                end
                per_cnt_d   = '0;
                seen_seed_d = 1'b1;
            end else if (per_cnt_q != '1) begin
                per_cnt_d = per_cnt_q + 1'b1;
            end

            if (q_in == '0) begin
                if (zero_cnt_q != ZW'(STUCK_CNT)) zero_cnt_d = zero_cnt_q + 1'b1;
            end else begin
                zero_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= HUNT;
            prev_q         <= '0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            zero_cnt_q     <= '0;
            per_cnt_q      <= '0;
            seen_seed_q    <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            zero_cnt_q     <= zero_cnt_d;
            per_cnt_q      <= per_cnt_d;
            seen_seed_q    <= seen_seed_d;
            err_pulse_q    <= err_pulse_d;
            err_cnt_q      <= err_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign locked       = (state_q == LOCK);
    assign err_pulse    = err_pulse_q;
    assign err_cnt      = err_cnt_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stuck_zero   = (zero_cnt_q == ZW'(STUCK_CNT));

endmodule

// File: tb/tb_lfsr_monitor.sv
// Directed and randomized stream checks of lfsr_monitor against a word-level reference model.
module tb_lfsr_monitor;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 3;
    localparam int STUCK_CNT  = 2;
    localparam int ERR_MAX    = 255;
    localparam int PER_MAX    = 255;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [5:0] q_in;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] period;
    logic       period_valid;
    logic       stuck_zero;

    int checks = 0;
    int errors = 0;

    lfsr_monitor #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .STUCK_CNT  (STUCK_CNT),
        .ERR_W      (8),
        .PER_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .q_in         (q_in),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_cnt      (err_cnt),
        .period       (period),
        .period_valid (period_valid),
        .stuck_zero   (stuck_zero)
    );

    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    // Reference model: mode 0 hunting, 1 syncing, 2 locked.
    int         m_mode, m_run, m_miss, m_err, m_pulse;
    logic [5:0] m_prev;
    int         m_idx, m_last_seed, m_period, m_pv, m_zrun;
    logic [5:0] cur;

    function automatic logic [5:0] ref_nxt(input logic [5:0] s);
        int v, msb;
        v   = int'(s);
        msb = v / 32;
        return 6'((((v * 2) % 64) + msb) ^ (msb * 8));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
        m_prev = '0; m_idx = 0; m_last_seed = -1; m_period = 0; m_pv = 0; m_zrun = 0;
    endtask

    task automatic model_word(input logic v, input logic [5:0] w);
        m_pulse = 0;
        if (!v) return;
        m_idx++;
        if (m_mode == 0) begin
            m_prev = w; m_run = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            m_run  = (w == ref_nxt(m_prev)) ? m_run + 1 : 0;
            m_prev = w;
            if (m_run == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
        end else begin
            if (w != ref_nxt(m_prev)) begin
                m_pulse = 1;
                m_err   = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                m_miss++;
            end else begin
                m_miss = 0;
            end
            m_prev = ref_nxt(m_prev);
            if (m_miss == UNLOCK_CNT) m_mode = 0;
        end
        if (w == 6'h3F) begin
            if (m_last_seed >= 0) begin
                m_period = (m_idx - m_last_seed > PER_MAX) ? PER_MAX : m_idx - m_last_seed;
                m_pv     = 1;
            end
            m_last_seed = m_idx;
        end
        m_zrun = (w == 6'h00) ? m_zrun + 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".locked"},       8'(locked),       8'(m_mode == 2));
        chk({ctx, ".err_pulse"},    8'(err_pulse),    8'(m_pulse));
        chk({ctx, ".err_cnt"},      err_cnt,          8'(m_err));
        chk({ctx, ".period"},       period,           8'(m_period));
        chk({ctx, ".period_valid"}, 8'(period_valid), 8'(m_pv));
        chk({ctx, ".stuck_zero"},   8'(stuck_zero),   8'(m_zrun >= STUCK_CNT));
    endtask

    task automatic step(input string ctx, input logic v, input logic [5:0] w);
        in_valid = v;
        q_in     = w;
        @(posedge clk);
        #1;
        model_word(v, w);
        check_outputs(ctx);
    endtask

    task automatic clean(input string ctx, input int n);
        for (int i = 0; i < n; i++) begin
            step(ctx, 1'b1, cur);
            cur = ref_nxt(cur);
        end
    endtask

    task automatic async_reset(input string ctx);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs({ctx, ".during"});
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        q_in = '0;
        model_reset();
        #20;
        check_outputs("reset");
        #5;
        rst = 1'b1;

        // 1: clean stream from the seed
        cur = 6'h3F;
        clean("s1", 4);
        chk("s1.not_yet_locked", 8'(locked), 8'd0);
        clean("s1", 1);
        chk("s1.locked_after_5", 8'(locked), 8'd1);
        clean("s1", 5);
        chk("s1.period9", period, 8'd9);
        chk("s1.pvalid", 8'(period_valid), 8'd1);

        // 2: single corrupted word in place of 1C
        while (cur != 6'h1C) clean("s2", 1);
        step("s2", 1'b1, 6'h2A);
        cur = ref_nxt(cur);
        chk("s2.one_err", err_cnt, 8'd1);
        chk("s2.pulse", 8'(err_pulse), 8'd1);
        clean("s2", 6);
        chk("s2.still_locked", 8'(locked), 8'd1);

        // 3: three consecutive bad words drop lock; relock after five clean
        for (int i = 0; i < 3; i++) begin
            step("s3", 1'b1, cur ^ 6'h15);
            cur = ref_nxt(cur);
        end
        chk("s3.unlocked", 8'(locked), 8'd0);
        chk("s3.err4", err_cnt, 8'd4);
        clean("s3", 5);
        chk("s3.relocked", 8'(locked), 8'd1);

        // 4: stuck at zero
        for (int i = 0; i < 4; i++) step("s4", 1'b1, 6'h00);
        chk("s4.stuck", 8'(stuck_zero), 8'd1);
        step("s4", 1'b1, 6'h3F);
        chk("s4.cleared", 8'(stuck_zero), 8'd0);

        // 5: gaps of two idle cycles between words
        async_reset("s5");
        cur = 6'h3F;
        for (int i = 0; i < 12; i++) begin
            step("s5", 1'b1, cur);
            cur = ref_nxt(cur);
            step("s5", 1'b0, $urandom);
            step("s5", 1'b0, $urandom);
        end
        chk("s5.period9", period, 8'd9);

        // 6: async reset while locked, then the clean-stream behaviour again
        async_reset("s6");
        cur = 6'h3F;
        clean("s6", 12);

        // randomized mix of gaps, corruptions and zero bursts
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 4) begin
                step("rnd", 1'b0, $urandom);
            end else if (r == 4) begin
                step("rnd", 1'b1, 6'($urandom));
                cur = ref_nxt(cur);
            end else if (r == 5) begin
                step("rnd", 1'b1, 6'h00);
            end else begin
                step("rnd", 1'b1, cur);
                cur = ref_nxt(cur);
            end
        end

        // error counter saturation
        for (int i = 0; i < 100; i++) begin
            clean("sat_err", 5);
            for (int j = 0; j < 3; j++) begin
                step("sat_err", 1'b1, cur ^ 6'h09);
                cur = ref_nxt(cur);
            end
        end
        chk("sat_err.max", err_cnt, 8'hFF);

        // period counter saturation over a long seedless run
        for (int i = 0; i < 300; i++) step("sat_per", 1'b1, 6'h00);
        step("sat_per", 1'b1, 6'h3F);
        chk("sat_per.max", period, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
